// File: rtl/ras_ckpt.sv
// Parametrised return-address stack with overflow/underflow pulses, pop+push replace
// and a single speculative checkpoint. Define RAS_OVF_STATS_EN to build the overflow counter.
module ras_ckpt #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_bp_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [VLEN-1:0]  data_i,
    input  logic             ckpt_save_i,
    input  logic             ckpt_restore_i,
    output logic             valid_o,
    output logic [VLEN-1:0]  data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             ckpt_valid_o,
    output logic [15:0]      ovf_cnt_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [VLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos;
    logic [CNT_W-1:0] count;
    logic             ckpt_valid;
    logic [PTR_W-1:0] saved_tos;
    logic [CNT_W-1:0] saved_count;
    logic [VLEN-1:0]  saved_top;
    logic             overflow;
    logic             underflow;

    logic [PTR_W-1:0] tos_inc;
    logic [PTR_W-1:0] tos_dec;
    logic [PTR_W-1:0] nxt_tos;
    logic [CNT_W-1:0] nxt_count;
    logic [VLEN-1:0]  nxt_top;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;
    logic             ovf_evt;
    logic             udf_evt;
    logic             restore_hit;

    // Explicit wrap keeps the circular buffer correct for non-power-of-two depths.
    assign tos_inc = (tos == LAST) ? '0 : tos + 1'b1;
    assign tos_dec = (tos == '0) ? LAST : tos - 1'b1;

    assign restore_hit = ckpt_restore_i & ckpt_valid;

    // Stack state as it stands after this cycle's push/pop; also what a save captures.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        nxt_tos   = tos;
        nxt_count = count;
        nxt_top   = mem[tos];
        wr_idx    = tos;
        wr_en     = 1'b0;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (push_i && (!pop_i || count == '0)) begin
            nxt_tos   = tos_inc;
            nxt_top   = data_i;
            wr_idx    = tos_inc;
            wr_en     = 1'b1;
            ovf_evt   = !pop_i && (count == FULL);
            nxt_count = (count == FULL) ? count : count + 1'b1;
        end else if (push_i && pop_i) begin
            nxt_top = data_i;
            wr_en   = 1'b1;
        end else if (pop_i) begin
            if (count != '0) begin
                nxt_tos   = tos_dec;
                nxt_count = count - 1'b1;
                nxt_top   = mem[tos_dec];
            end else begin
                udf_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the entries are reset because data_o must read zero straight out of reset.
            mem         <= '{default: '0};
            tos         <= '0;
            count       <= '0;
            ckpt_valid  <= 1'b0;
            saved_tos   <= '0;
            saved_count <= '0;
            saved_top   <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (flush_bp_i) begin
            tos        <= '0;
            count      <= '0;
            ckpt_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (restore_hit) begin
            tos            <= saved_tos;
            count          <= saved_count;
            mem[saved_tos] <= saved_top;
            ckpt_valid     <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            tos       <= nxt_tos;
            count     <= nxt_count;
            overflow  <= ovf_evt;
            underflow <= udf_evt;
            if (wr_en) begin
                mem[wr_idx] <= data_i;
            end
            if (ckpt_save_i) begin
                saved_tos   <= nxt_tos;
                saved_count <= nxt_count;
                saved_top   <= nxt_top;
                ckpt_valid  <= 1'b1;
            end
        end
    end

`ifdef RAS_OVF_STATS_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_cnt <= '0;
        end else if (flush_bp_i) begin
            ovf_cnt <= '0;
        end else if (ovf_evt && !restore_hit && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    assign ovf_cnt_o = ovf_cnt;
`else
    assign ovf_cnt_o = 16'h0;
`endif

    assign data_o       = mem[tos];
    assign valid_o      = (count != '0);
    assign count_o      = count;
    assign overflow_o   = overflow;
    assign underflow_o  = underflow;
    assign ckpt_valid_o = ckpt_valid;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: three instances (DEPTH 2, 3, 4) driven independently
// with hand-computed expectations.
module tb_ras_ckpt;

`ifdef RAS_OVF_STATS_EN
    localparam logic [15:0] EXP_OVF = 16'd3;
`else
    localparam logic [15:0] EXP_OVF = 16'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic        flush [3];
    logic        push  [3];
    logic        pop   [3];
    logic [63:0] din   [3];
    logic        save  [3];
    logic        rest  [3];
    logic        valid [3];
    logic [63:0] dout  [3];
    logic [7:0]  cnt   [3];
    logic        ovf   [3];
    logic        udf   [3];
    logic        ckv   [3];
    logic [15:0] ovfc  [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D  = g + 2;
        localparam int unsigned CW = $clog2(D + 1);
        logic [CW-1:0] cnt_raw;

        ras_ckpt #(.DEPTH(D), .VLEN(64)) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .flush_bp_i     (flush[g]),
            .push_i         (push[g]),
            .pop_i          (pop[g]),
            .data_i         (din[g]),
            .ckpt_save_i    (save[g]),
            .ckpt_restore_i (rest[g]),
            .valid_o        (valid[g]),
            .data_o         (dout[g]),
            .count_o        (cnt_raw),
            .overflow_o     (ovf[g]),
            .underflow_o    (udf[g]),
            .ckpt_valid_o   (ckv[g]),
            .ovf_cnt_o      (ovfc[g])
        );

        assign cnt[g] = 8'(cnt_raw);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One cycle of stimulus on instance g; returns 1 time unit after the edge.
    task automatic step(input int g, input logic ps, input logic pp, input logic [63:0] d,
                        input logic sv, input logic rs, input logic fl);
        push[g]  = ps;
        pop[g]   = pp;
        din[g]   = d;
        save[g]  = sv;
        rest[g]  = rs;
        flush[g] = fl;
        @(posedge clk);
        #1;
        push[g]  = 1'b0;
        pop[g]   = 1'b0;
        din[g]   = '0;
        save[g]  = 1'b0;
        rest[g]  = 1'b0;
        flush[g] = 1'b0;
    endtask

    task automatic do_push(input int g, input logic [63:0] d);
        step(g, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_pop(input int g);
        step(g, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            flush[g] = 1'b0; push[g] = 1'b0; pop[g] = 1'b0;
            din[g] = '0; save[g] = 1'b0; rest[g] = 1'b0;
        end
        #3;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_valid%0d", g), 64'(valid[g]), 64'd0);
            check($sformatf("rst_data%0d", g), dout[g], 64'd0);
            check($sformatf("rst_count%0d", g), 64'(cnt[g]), 64'd0);
            check($sformatf("rst_ovf%0d", g), 64'(ovf[g]), 64'd0);
            check($sformatf("rst_udf%0d", g), 64'(udf[g]), 64'd0);
            check($sformatf("rst_ckv%0d", g), 64'(ckv[g]), 64'd0);
            check($sformatf("rst_ovfc%0d", g), 64'(ovfc[g]), 64'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // DEPTH=2 basic push/pop
        do_push(0, 64'h100);
        do_push(0, 64'h200);
        check("d2_count2", 64'(cnt[0]), 64'd2);
        check("d2_top200", dout[0], 64'h200);
        check("d2_valid", 64'(valid[0]), 64'd1);
        do_pop(0);
        check("d2_pop_top", dout[0], 64'h100);
        check("d2_pop_count", 64'(cnt[0]), 64'd1);
        do_pop(0);
        check("d2_empty", 64'(cnt[0]), 64'd0);

        // DEPTH=2 overflow then underflow
        do_push(0, 64'hA);
        do_push(0, 64'hB);
        check("d2_no_ovf", 64'(ovf[0]), 64'd0);
        do_push(0, 64'hC);
        check("d2_ovf", 64'(ovf[0]), 64'd1);
        check("d2_ovf_count", 64'(cnt[0]), 64'd2);
        step(0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("d2_ovf_pulse", 64'(ovf[0]), 64'd0);
        check("d2_popC", dout[0], 64'hC);
        do_pop(0);
        check("d2_popB", dout[0], 64'hB);
        do_pop(0);
        check("d2_no_udf", 64'(udf[0]), 64'd0);
        do_pop(0);
        check("d2_udf", 64'(udf[0]), 64'd1);
        check("d2_udf_count", 64'(cnt[0]), 64'd0);

        // DEPTH=3 replace, replace-while-empty, non-power-of-two wrap
        do_push(1, 64'h10);
        step(1, 1'b1, 1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
        check("d3_rep_count", 64'(cnt[1]), 64'd1);
        check("d3_rep_top", dout[1], 64'h20);
        do_pop(1);
        step(1, 1'b1, 1'b1, 64'h30, 1'b0, 1'b0, 1'b0);
        check("d3_rep_empty_count", 64'(cnt[1]), 64'd1);
        check("d3_rep_empty_udf", 64'(udf[1]), 64'd0);
        check("d3_rep_empty_top", dout[1], 64'h30);
        do_push(1, 64'h41);
        do_push(1, 64'h42);
        do_push(1, 64'h43);
        check("d3_wrap_ovf", 64'(ovf[1]), 64'd1);
        check("d3_wrap_top", dout[1], 64'h43);
        do_pop(1);
        check("d3_wrap_pop1", dout[1], 64'h42);
        do_pop(1);
        check("d3_wrap_pop2", dout[1], 64'h41);
        check("d3_wrap_count", 64'(cnt[1]), 64'd1);

        // DEPTH=4 checkpoint save/restore
        do_push(2, 64'h1);
        do_push(2, 64'h2);
        step(2, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("d4_ckv_set", 64'(ckv[2]), 64'd1);
        do_pop(2);
        do_pop(2);
        do_push(2, 64'h9);
        step(2, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("d4_rst_count", 64'(cnt[2]), 64'd2);
        check("d4_rst_top", dout[2], 64'h2);
        check("d4_rst_ckv", 64'(ckv[2]), 64'd0);
        step(2, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("d4_rst2_count", 64'(cnt[2]), 64'd2);
        check("d4_rst2_top", dout[2], 64'h2);
        do_pop(2);
        check("d4_below_top", dout[2], 64'h9);
        step(2, 1'b1, 1'b0, 64'h77, 1'b1, 1'b0, 1'b0);
        check("d4_save_push_ckv", 64'(ckv[2]), 64'd1);
        do_push(2, 64'h88);
        do_pop(2);
        do_pop(2);
        do_push(2, 64'h99);
        check("d4_clobber_top", dout[2], 64'h99);
        step(2, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("d4_saved_top", dout[2], 64'h77);
        check("d4_saved_count", 64'(cnt[2]), 64'd2);
        step(2, 1'b1, 1'b0, 64'hAB, 1'b0, 1'b1, 1'b0);
        check("d4_inv_rst_count", 64'(cnt[2]), 64'd3);
        check("d4_inv_rst_top", dout[2], 64'hAB);

        // DEPTH=2 overflow statistics and flush priority
        step(0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("fl_ckv_set", 64'(ckv[0]), 64'd1);
        for (int i = 0; i < 5; i++) do_push(0, 64'(i + 'h60));
        check("fl_ovf_last", 64'(ovf[0]), 64'd1);
        check("fl_ovfc", 64'(ovfc[0]), 64'(EXP_OVF));
        step(0, 1'b1, 1'b0, 64'h55, 1'b0, 1'b1, 1'b1);
        check("fl_count", 64'(cnt[0]), 64'd0);
        check("fl_ckv", 64'(ckv[0]), 64'd0);
        check("fl_valid", 64'(valid[0]), 64'd0);
        check("fl_ovf", 64'(ovf[0]), 64'd0);
        check("fl_udf", 64'(udf[0]), 64'd0);
        check("fl_ovfc_clr", 64'(ovfc[0]), 64'd0);

        // Asynchronous reset mid-sequence
        do_push(0, 64'h5);
        check("ar_pre_top", dout[0], 64'h5);
        #2 rst_n = 1'b0;
        #1;
        check("ar_count", 64'(cnt[0]), 64'd0);
        check("ar_valid", 64'(valid[0]), 64'd0);
        check("ar_data", dout[0], 64'd0);
        check("ar_ckv", 64'(ckv[2]), 64'd0);
        check("ar_d4_data", dout[2], 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
